// File: rtl/median_arbiter_if.sv
// rtl/median_arbiter_if.sv - requester and median-core signal bundle for median_arbiter
interface median_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  REQ0;
    logic                  REQ1;
    logic                  DSI0;
    logic                  DSI1;
    logic [DATA_WIDTH-1:0] DI0;
    logic [DATA_WIDTH-1:0] DI1;
    logic                  GNT0;
    logic                  GNT1;
    logic                  DONE0;
    logic                  DONE1;
    logic [DATA_WIDTH-1:0] DO;
    logic                  ERR;
    logic                  M_DSI;
    logic [DATA_WIDTH-1:0] M_DI;
    logic [DATA_WIDTH-1:0] M_DO;
    logic                  M_DSO;

    modport slave (
        input  REQ0, REQ1, DSI0, DSI1, DI0, DI1, M_DO, M_DSO,
        output GNT0, GNT1, DONE0, DONE1, DO, ERR, M_DSI, M_DI
    );

    modport master (
        output REQ0, REQ1, DSI0, DSI1, DI0, DI1, M_DO, M_DSO,
        input  GNT0, GNT1, DONE0, DONE1, DO, ERR, M_DSI, M_DI
    );
endinterface

// File: rtl/median_arbiter.sv
// rtl/median_arbiter.sv - round-robin arbiter feeding two requesters' 9-pixel windows to one median core
module median_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 63
) (
    input  logic             CLK,
    input  logic             nRST,
    median_arbiter_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, COLLECT, BURST, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  last_q, last_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [3:0]            bcnt_q, bcnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic [DATA_WIDTH-1:0] pix_q [9];
    logic                  buf_we;

    logic                  req_sel;
    logic                  dsi_sel;
    logic [DATA_WIDTH-1:0] di_sel;

    // Only the granted requester's lines are ever looked at past arbitration.
    assign req_sel = sel_q ? bus.REQ1 : bus.REQ0;
    assign dsi_sel = sel_q ? bus.DSI1 : bus.DSI0;
    assign di_sel  = sel_q ? bus.DI1  : bus.DI0;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        err_d   = err_q;
        do_d    = do_q;
        buf_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.REQ0 || bus.REQ1) begin
                    // last_q names the requester served last; the other wins a tie.
                    sel_d   = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;
                    gnt_d   = sel_d ? 2'b10 : 2'b01;
                    wcnt_d  = 4'd0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!req_sel) begin
                    gnt_d   = 2'b00;
                    wcnt_d  = 4'd0;
                    state_d = IDLE;
                end else if (dsi_sel) begin
                    buf_we = 1'b1;
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == 4'd8) begin
                        bcnt_d  = 4'd0;
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (bcnt_q == 4'd8) begin
                    bcnt_d  = 4'd0;
                    tcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    bcnt_d = bcnt_q + 4'd1;
                end
            end
            WAIT: begin
                // A result arriving on the final count still wins over the timeout.
                if (bus.M_DSO) begin
                    do_d    = bus.M_DO;
                    err_d   = 1'b0;
                    last_d  = sel_q;
                    state_d = DONE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    last_d  = sel_q;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                err_d   = 1'b0;
                wcnt_d  = 4'd0;
                tcnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            wcnt_q  <= 4'd0;
            bcnt_q  <= 4'd0;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            do_q    <= do_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 9; i++) pix_q[i] <= '0;
        end else if (buf_we) begin
            pix_q[wcnt_q] <= di_sel;
        end
    end

    assign bus.GNT0  = gnt_q[0];
    assign bus.GNT1  = gnt_q[1];
    assign bus.DONE0 = (state_q == DONE) && !sel_q;
    assign bus.DONE1 = (state_q == DONE) && sel_q;
    assign bus.ERR   = (state_q == DONE) && err_q;
    assign bus.DO    = do_q;
    assign bus.M_DSI = (state_q == BURST);
    assign bus.M_DI  = (state_q == BURST) ? pix_q[bcnt_q] : '0;
endmodule

// File: tb/tb_median_arbiter.sv
// tb/tb_median_arbiter.sv - randomized directed bench for median_arbiter with a sorting core model
module tb_median_arbiter;
    localparam int TIMEOUT = 63;

    logic clk;
    logic rst_n;

    median_arbiter_if #(.DATA_WIDTH(8)) bus ();

    median_arbiter #(.DATA_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] pix [9];
    int         core_lat;
    int         model_last;
    logic [7:0] exp_do;
    logic [3:0] grant_order;

    int         cyc = 0, run = 0, last_run = 0, last_dsi_cyc = 0, done_cyc = 0;
    int         dsi_total = 0, done0_n = 0, done1_n = 0, overlap = 0;
    logic [7:0] burst_q [$];
    logic [7:0] cq [$];
    logic [7:0] med_c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Bus monitor: sampled on the falling edge, away from the DUT's active edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                run = 0;
            end else begin
                if (bus.GNT0 && bus.GNT1) overlap++;
                if (bus.M_DSI) begin
                    run++;
                    dsi_total++;
                    last_dsi_cyc = cyc;
                    burst_q.push_back(bus.M_DI);
                end else if (run > 0) begin
                    last_run = run;
                    run = 0;
                end
                if (bus.DONE0) begin done0_n++; done_cyc = cyc; end
                if (bus.DONE1) begin done1_n++; done_cyc = cyc; end
            end
        end
    end

    // Median core model: gathers 9 strobed pixels, returns the sorted middle after core_lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cq.delete();
            end else if (bus.M_DSI) begin
                cq.push_back(bus.M_DI);
                if (cq.size() == 9) begin
                    cq.sort();
                    med_c = cq[4];
                    cq.delete();
                    if (core_lat > 0) begin
                        repeat (core_lat) @(posedge clk);
                        #1 bus.M_DO = med_c;
                        bus.M_DSO = 1'b1;
                        @(posedge clk);
                        #1 bus.M_DSO = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] median9();
        int q [$];
        for (int k = 0; k < 9; k++) q.push_back(int'(pix[k]));
        q.sort();
        return 8'(q[4]);
    endfunction

    task automatic fill_random();
        for (int k = 0; k < 9; k++) pix[k] = 8'($urandom);
    endtask

    task automatic drive(input int n, input logic v, input logic [7:0] d);
        if (n == 0) begin bus.DSI0 = v; bus.DI0 = d; end
        else        begin bus.DSI1 = v; bus.DI1 = d; end
    endtask

    task automatic set_req(input int n, input logic v);
        if (n == 0) bus.REQ0 = v;
        else        bus.REQ1 = v;
    endtask

    // The other requester strobes junk throughout; it must never reach the buffer.
    task automatic send_pix(input int n, input int count, input int gapmax);
        int gap;
        for (int k = 0; k < count; k++) begin
            gap = (gapmax > 0) ? int'($urandom_range(gapmax, 1)) : 0;
            repeat (gap) begin
                @(posedge clk);
                #1 drive(n, 1'b0, 8'h00);
                drive(1 - n, 1'b1, 8'($urandom));
            end
            @(posedge clk);
            #1 drive(n, 1'b1, pix[k]);
            drive(1 - n, 1'b1, 8'($urandom));
        end
        @(posedge clk);
        #1 drive(n, 1'b0, 8'h00);
        drive(1 - n, 1'b0, 8'h00);
    endtask

    task automatic do_txn(input int n, input int gapmax);
        logic [7:0] med;
        logic       exp_err;
        int         d0, d1, bad;
        exp_err = (core_lat < 0);
        med = median9();
        for (int i = 0; i < 20 && !(bus.GNT0 || bus.GNT1); i++) tick();
        check("grant", 32'({bus.GNT1, bus.GNT0}), 32'(1 << n));
        grant_order = {grant_order[2:0], bus.GNT1};
        burst_q.delete();
        d0 = done0_n;
        d1 = done1_n;
        send_pix(n, 9, gapmax);
        for (int i = 0; i < 300 && !(bus.DONE0 || bus.DONE1); i++) tick();
        check("done_sel", 32'({bus.DONE1, bus.DONE0}), 32'(1 << n));
        check("err_flag", 32'(bus.ERR), 32'(exp_err));
        if (!exp_err) exp_do = med;
        check("do_value", 32'(bus.DO), 32'(exp_do));
        check("done_latency", 32'(done_cyc - last_dsi_cyc),
              32'(exp_err ? TIMEOUT + 1 : core_lat + 1));
        check("burst_len", 32'(last_run), 32'd9);
        check("burst_count", 32'(burst_q.size()), 32'd9);
        bad = 0;
        for (int k = 0; k < 9; k++)
            if (k >= burst_q.size() || burst_q[k] !== pix[k]) bad++;
        check("burst_order", 32'(bad), 32'd0);
        @(posedge clk);
        #1 set_req(n, 1'b0);
        tick();
        check("after_done", 32'({bus.DONE0, bus.DONE1, bus.ERR, bus.GNT0, bus.GNT1}), 32'd0);
        check("done_pulses", 32'((done0_n - d0) + (done1_n - d1)), 32'd1);
        model_last = n;
    endtask

    initial begin
        int w, n, d1s, dsis, d0s;
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        bus.DSI0 = 1'b0; bus.DSI1 = 1'b0;
        bus.DI0 = 8'h00; bus.DI1 = 8'h00;
        bus.M_DO = 8'h00; bus.M_DSO = 1'b0;
        core_lat = 10; model_last = 1; exp_do = 8'h00; grant_order = 4'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_outputs", 32'({bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.ERR,
                                        bus.M_DSI, bus.M_DI, bus.DO}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // Stray core strobe while idle must not be captured.
        @(posedge clk);
        #1 bus.M_DO = 8'hA5; bus.M_DSO = 1'b1;
        @(posedge clk);
        #1 bus.M_DSO = 1'b0;
        tick();
        check("stray_mdso_do", 32'(bus.DO), 32'(exp_do));
        check("stray_mdso_done", 32'({bus.DONE0, bus.DONE1, bus.ERR}), 32'd0);

        // Fixed window, requester 0 alone.
        pix = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        @(posedge clk);
        #1 bus.REQ0 = 1'b1;
        tick();
        check("gnt_before_edge", 32'({bus.GNT1, bus.GNT0}), 32'd0);
        tick();
        check("gnt_next_cycle", 32'({bus.GNT1, bus.GNT0}), 32'd1);
        do_txn(0, 0);

        // Requester 1 with strobe gaps.
        fill_random();
        core_lat = 7;
        @(posedge clk);
        #1 bus.REQ1 = 1'b1;
        do_txn(1, 3);

        // Simultaneous requests, twice.
        grant_order = 4'h0;
        for (int rep = 0; rep < 2; rep++) begin
            fill_random();
            core_lat = int'($urandom_range(30, 1));
            @(posedge clk);
            #1 bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
            w = (model_last == 0) ? 1 : 0;
            do_txn(w, 0);
            fill_random();
            do_txn(1 - w, 1);
        end
        check("rr_order", 32'(grant_order), 32'b0101);

        // Requester 1 aborts after 4 pixels while requester 0 waits.
        fill_random();
        @(posedge clk);
        #1 bus.REQ1 = 1'b1;
        for (int i = 0; i < 20 && !(bus.GNT0 || bus.GNT1); i++) tick();
        check("abort_grant", 32'({bus.GNT1, bus.GNT0}), 32'd2);
        send_pix(1, 4, 0);
        @(posedge clk);
        #1 bus.REQ0 = 1'b1;
        @(posedge clk);
        #1 bus.REQ1 = 1'b0;
        dsis = dsi_total;
        d1s = done1_n;
        tick();
        tick();
        check("abort_gnt_low", 32'({bus.GNT1, bus.GNT0}), 32'd0);
        tick();
        check("abort_next_grant", 32'({bus.GNT1, bus.GNT0}), 32'd1);
        check("abort_no_mdsi", 32'(dsi_total - dsis), 32'd0);
        check("abort_no_done", 32'(done1_n - d1s), 32'd0);
        fill_random();
        do_txn(0, 0);

        // Core never answers: timeout path.
        core_lat = -1;
        fill_random();
        @(posedge clk);
        #1 bus.REQ0 = 1'b1;
        do_txn(0, 1);
        core_lat = 12;

        // Asynchronous reset in the middle of a burst.
        fill_random();
        @(posedge clk);
        #1 bus.REQ0 = 1'b1;
        for (int i = 0; i < 20 && !(bus.GNT0 || bus.GNT1); i++) tick();
        send_pix(0, 9, 0);
        for (int i = 0; i < 20 && !bus.M_DSI; i++) tick();
        check("burst_started", 32'(bus.M_DSI), 32'd1);
        tick();
        tick();
        d0s = done0_n;
        #2 rst_n = 1'b0;
        bus.REQ0 = 1'b0;
        #1 check("async_reset_outputs", 32'({bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.ERR,
                                              bus.M_DSI, bus.M_DI, bus.DO}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_last = 1;
        exp_do = 8'h00;
        tick();
        check("post_reset_idle", 32'({bus.GNT0, bus.GNT1, bus.M_DSI, bus.DO}), 32'd0);
        check("reset_no_done", 32'(done0_n - d0s), 32'd0);
        fill_random();
        @(posedge clk);
        #1 bus.REQ0 = 1'b1;
        do_txn(0, 0);

        // Random requesters, latencies and gaps.
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 0));
            core_lat = int'($urandom_range(40, 1));
            fill_random();
            @(posedge clk);
            #1 set_req(n, 1'b1);
            do_txn(n, int'($urandom_range(2, 0)));
        end

        check("grant_overlap", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
